// File: rtl/mips_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

    // One register-file write: used for port A, port B and the committed output.
    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] rd;
        logic [DATA_W_DEF-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for destinations of outstanding long-latency ops.
// Produces the issue gate and the decode read-operand stall.
module rf_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_rd,
    input  logic                 clr_en,
    input  logic [ADDR_W-1:0]    clr_rd,
    input  logic [ADDR_W-1:0]    rs,
    input  logic [ADDR_W-1:0]    rt,
    output logic                 issue_ready,
    output logic                 stall,
    output logic [2**ADDR_W-1:0] busy
);

    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    // Gate and stall look only at the registered busy bits.
    always_comb begin
        issue_ready = (issue_rd == '0) || !busy[issue_rd];
        stall       = ((rs != '0) && busy[rs]) || ((rt != '0) && busy[rt]);
    end

    // Decode set/clear requests into one-hot vectors; r0 is never tracked.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && issue_ready && (issue_rd != '0))
            set_vec[issue_rd] = 1'b1;
        if (clr_en && (clr_rd != '0))
            clr_vec[clr_rd] = 1'b1;
    end

    // Busy bits: clear first, then set, so a same-index set wins.
    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= (busy & ~clr_vec) | set_vec;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback (A, always wins) and a long-latency unit (B, valid/ready),
// with a starvation counter that requests a pipeline bubble for B.
// Optional macro RFWB_BYPASS_EN adds same-cycle forwarding outputs.
module regfile_wb_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              stall,
    output logic              pipe_hold,
    output logic              waw_err,
`ifdef RFWB_BYPASS_EN
    output logic [DATA_W-1:0] fwd_one,
    output logic [DATA_W-1:0] fwd_two,
    output logic              fwd_hit_one,
    output logic              fwd_hit_two,
`endif
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_data
);

    localparam int              CW   = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]   SMAX = CW'(STARVE_MAX);

    logic                 a_req;
    logic                 b_grant;
    wb_req_t              wr_nxt;
    wb_req_t              wr_q;
    logic [CW-1:0]        starve_cnt;
    logic [CW-1:0]        starve_nxt;
    logic [2**ADDR_W-1:0] busy;

    rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .clr_en      (b_grant),
        .clr_rd      (b_rd),
        .rs          (rs),
        .rt          (rt),
        .issue_ready (issue_ready),
        .stall       (stall),
        .busy        (busy)
    );

    // Grant: A wins when it really writes; otherwise a valid B is taken.
    // Writes to r0 are accepted but never reach the register file.
    always_comb begin
        a_req   = a_we && (a_rd != REG_ZERO);
        b_grant = b_valid && !a_req;
        b_ready = b_grant;
        wr_nxt  = '0;
        if (a_req)
            wr_nxt = '{we: 1'b1, rd: a_rd, data: a_data};
        else if (b_grant && (b_rd != REG_ZERO))
            wr_nxt = '{we: 1'b1, rd: b_rd, data: b_data};
    end

    // Consecutive B losses, saturating so the hold request persists.
    always_comb begin
        starve_nxt = '0;
        if (b_valid && !b_grant)
            starve_nxt = (starve_cnt == SMAX) ? SMAX : starve_cnt + 1'b1;
    end

    // Commit registers, starvation state and the sticky WAW flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            starve_cnt <= '0;
            pipe_hold  <= 1'b0;
            waw_err    <= 1'b0;
        end else begin
            wr_q       <= wr_nxt;
            starve_cnt <= starve_nxt;
            pipe_hold  <= (starve_nxt == SMAX);
            if (a_req && busy[a_rd])
                waw_err <= 1'b1;
        end
    end

    assign rf_we   = wr_q.we;
    assign rf_rd   = wr_q.rd;
    assign rf_data = wr_q.data;

`ifdef RFWB_BYPASS_EN
    // Forward the in-flight write to decode during the write-then-read window.
    always_comb begin
        fwd_hit_one = rf_we && (rf_rd == rs) && (rs != REG_ZERO);
        fwd_hit_two = rf_we && (rf_rd == rt) && (rt != REG_ZERO);
        fwd_one     = fwd_hit_one ? rf_data : '0;
        fwd_two     = fwd_hit_two ? rf_data : '0;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a per-cycle reference model
// plus directed scenarios with literal expectations.
module tb_regfile_wb_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_we, b_valid, issue_valid;
    logic [4:0]  a_rd, b_rd, issue_rd, rs, rt;
    logic [31:0] a_data, b_data;
    logic        b_ready, issue_ready, stall, pipe_hold, waw_err;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
`ifdef RFWB_BYPASS_EN
    logic [31:0] fwd_one, fwd_two;
    logic        fwd_hit_one, fwd_hit_two;
`endif

    int errors = 0;
    int checks = 0;
    bit started = 0;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs(rs), .rt(rt), .stall(stall), .pipe_hold(pipe_hold), .waw_err(waw_err),
`ifdef RFWB_BYPASS_EN
        .fwd_one(fwd_one), .fwd_two(fwd_two),
        .fwd_hit_one(fwd_hit_one), .fwd_hit_two(fwd_hit_two),
`endif
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state updated once per rising edge.
    bit          m_busy [32];
    int          m_loss;
    bit          m_hold, m_waw, m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    always @(posedge clk) begin
        bit a_wins, b_wins;
        bit nb [32];
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_loss = 0; m_hold = 0; m_waw = 0;
            m_we = 0; m_rd = 0; m_data = 0;
        end else begin
            a_wins = a_we && (a_rd != 0);
            b_wins = b_valid && !a_wins;
            if (a_wins) begin
                m_we = 1; m_rd = a_rd; m_data = a_data;
                if (m_busy[a_rd]) m_waw = 1;
            end else if (b_wins && b_rd != 0) begin
                m_we = 1; m_rd = b_rd; m_data = b_data;
            end else begin
                m_we = 0; m_rd = 0; m_data = 0;
            end
            nb = m_busy;
            if (b_wins && b_rd != 0) nb[b_rd] = 0;
            if (issue_valid && issue_rd != 0 && !m_busy[issue_rd]) nb[issue_rd] = 1;
            m_busy = nb;
            if (b_valid && !b_wins) m_loss = (m_loss + 1 > SMAX) ? SMAX : m_loss + 1;
            else m_loss = 0;
            m_hold = (m_loss == SMAX);
        end
    end

    // Compare every cycle on the falling edge once the first reset is done.
    always @(negedge clk) begin
        if (started) begin
            chk("rf_we",       {31'b0, rf_we}, {31'b0, m_we});
            chk("rf_rd",       {27'b0, rf_rd}, {27'b0, m_rd});
            chk("rf_data",     rf_data, m_data);
            chk("pipe_hold",   {31'b0, pipe_hold}, {31'b0, m_hold});
            chk("waw_err",     {31'b0, waw_err}, {31'b0, m_waw});
            chk("b_ready",     {31'b0, b_ready}, {31'b0, b_valid && !(a_we && a_rd != 0)});
            chk("issue_ready", {31'b0, issue_ready}, {31'b0, issue_rd == 0 || !m_busy[issue_rd]});
            chk("stall",       {31'b0, stall},
                {31'b0, (rs != 0 && m_busy[rs]) || (rt != 0 && m_busy[rt])});
`ifdef RFWB_BYPASS_EN
            chk("fwd_hit_one", {31'b0, fwd_hit_one}, {31'b0, m_we && m_rd == rs && rs != 0});
            chk("fwd_one", fwd_one, (m_we && m_rd == rs && rs != 0) ? m_data : 32'h0);
            chk("fwd_hit_two", {31'b0, fwd_hit_two}, {31'b0, m_we && m_rd == rt && rt != 0});
            chk("fwd_two", fwd_two, (m_we && m_rd == rt && rt != 0) ? m_data : 32'h0);
`endif
        end
    end

    // Advance to just after the next rising edge, where inputs change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle();
        a_we = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    initial begin
        int hold_at, grant_at;
        rst = 1; rs = 0; rt = 0;
        idle();
        step(); step();
        rst = 0;
        started = 1;
        at_neg();
        chk("reset rf_we", {31'b0, rf_we}, 32'h0);
        chk("reset pipe_hold", {31'b0, pipe_hold}, 32'h0);
        chk("reset waw_err", {31'b0, waw_err}, 32'h0);

        // 1: plain A write, one-cycle commit latency
        step();
        a_we = 1; a_rd = 5; a_data = 32'h12345678;
        at_neg();
        chk("t1 b_ready", {31'b0, b_ready}, 32'h0);
        step();
        idle();
        at_neg();
        chk("t1 rf_we", {31'b0, rf_we}, 32'h1);
        chk("t1 rf_rd", {27'b0, rf_rd}, 32'd5);
        chk("t1 rf_data", rf_data, 32'h12345678);

        // 2: issue rd 9, then B returns it with A idle
        step();
        issue_valid = 1; issue_rd = 9;
        step();
        issue_valid = 0; issue_rd = 0; rs = 9;
        at_neg();
        chk("t2 stall before", {31'b0, stall}, 32'h1);
        step();
        b_valid = 1; b_rd = 9; b_data = 32'hDEAD;
        at_neg();
        chk("t2 b_ready", {31'b0, b_ready}, 32'h1);
        step();
        idle();
        at_neg();
        chk("t2 stall after", {31'b0, stall}, 32'h0);
        chk("t2 rf_data", rf_data, 32'hDEAD);
        rs = 0;

        // 3: B starved by A until the hold bubble
        step();
        hold_at = -1; grant_at = -1;
        b_valid = 1; b_rd = 12; b_data = 32'hBEEF;
        for (int i = 0; i < 10; i++) begin
            a_we = !pipe_hold; a_rd = 5'(1 + i); a_data = i;
            at_neg();
            if (pipe_hold && hold_at < 0) hold_at = i;
            if (b_ready) begin grant_at = i; break; end
            step();
        end
        chk("t3 hold cycle", hold_at, 4);
        chk("t3 grant cycle", grant_at, 4);
        step();
        idle();
        at_neg();
        chk("t3 hold cleared", {31'b0, pipe_hold}, 32'h0);
        chk("t3 rf_data", rf_data, 32'hBEEF);
        // A ignores the hold: counter saturates, hold stays up
        step();
        b_valid = 1; b_rd = 12; b_data = 32'hCAFE;
        for (int i = 0; i < 7; i++) begin
            a_we = 1; a_rd = 5'(1 + i); a_data = 32'h100 + i;
            step();
        end
        at_neg();
        chk("t3 hold sustained", {31'b0, pipe_hold}, 32'h1);
        a_we = 0;
        step();
        idle();

        // 4: double issue to rd 7 is refused; set beats clear on one index
        step();
        issue_valid = 1; issue_rd = 7;
        step();
        at_neg();
        chk("t4 second issue_ready", {31'b0, issue_ready}, 32'h0);
        step();
        idle();
        b_valid = 1; b_rd = 7; b_data = 32'h7;
        step();
        idle();
        b_valid = 1; b_rd = 7; b_data = 32'h77;
        issue_valid = 1; issue_rd = 7;
        step();
        idle();
        rs = 7;
        at_neg();
        chk("t4 busy7 kept", {31'b0, stall}, 32'h1);
        b_valid = 1; b_rd = 7; b_data = 32'h777;
        step();
        idle(); rs = 0;

        // 5: r0 writes dropped; A overwriting a busy register flags WAW
        step();
        a_we = 1; a_rd = 0; a_data = 32'hFFFF;
        b_valid = 1; b_rd = 0; b_data = 32'hEEEE;
        at_neg();
        chk("t5 b_ready r0", {31'b0, b_ready}, 32'h1);
        step();
        idle();
        at_neg();
        chk("t5 rf_we r0", {31'b0, rf_we}, 32'h0);
        step();
        issue_valid = 1; issue_rd = 9;
        step();
        idle();
        a_we = 1; a_rd = 9; a_data = 32'h99;
        step();
        idle();
        at_neg();
        chk("t5 rf_rd waw", {27'b0, rf_rd}, 32'd9);
        chk("t5 waw_err", {31'b0, waw_err}, 32'h1);
        step(); step();
        at_neg();
        chk("t5 waw sticky", {31'b0, waw_err}, 32'h1);

        // 6: reset in the middle of starvation with busy 3 and 9
        step();
        issue_valid = 1; issue_rd = 3;
        step();
        issue_valid = 0; issue_rd = 0;
        b_valid = 1; b_rd = 3; b_data = 32'h3;
        for (int i = 0; i < 3; i++) begin
            a_we = 1; a_rd = 5'(20 + i); a_data = i;
            step();
        end
        rst = 1;
        step();
        rst = 0; idle(); rs = 9; rt = 3;
        at_neg();
        chk("t6 rf_we", {31'b0, rf_we}, 32'h0);
        chk("t6 stall", {31'b0, stall}, 32'h0);
        chk("t6 waw_err", {31'b0, waw_err}, 32'h0);
        chk("t6 pipe_hold", {31'b0, pipe_hold}, 32'h0);
        step();
        rs = 4; rt = 0;
        a_we = 1; a_rd = 4; a_data = 32'hA5A5A5A5;
        step();
        idle();
        at_neg();
`ifdef RFWB_BYPASS_EN
        chk("t6 fwd_hit_one", {31'b0, fwd_hit_one}, 32'h1);
        chk("t6 fwd_one", fwd_one, 32'hA5A5A5A5);
`else
        chk("t6 rf_data", rf_data, 32'hA5A5A5A5);
`endif
        step(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
